// File: rtl/puneh_seq_ctrl_if.sv
// Handshake/bus bundle between the PUNEH sequencer and its IR, memory and decode logic.
// PUNEH_STEP_MODE_EN adds the step_go single-step release input.
interface puneh_seq_ctrl_if #(
  parameter int unsigned IW = 16
);
  logic [IW-1:0] inst;
  logic          mem_ack;
  logic          irq;
  logic          ie_set;
`ifdef PUNEH_STEP_MODE_EN
  logic          step_go;
`endif
  logic          mem_req;
  logic          ir_ld;
  logic          commit_e1;
  logic          commit_e2;
  logic          irq_save;
  logic          irq_ack;
  logic          bus_err;
  logic [2:0]    state;

  modport master (
`ifdef PUNEH_STEP_MODE_EN
    output step_go,
`endif
    output inst, mem_ack, irq, ie_set,
    input  mem_req, ir_ld, commit_e1, commit_e2, irq_save, irq_ack, bus_err, state
  );

  modport slave (
`ifdef PUNEH_STEP_MODE_EN
    input  step_go,
`endif
    input  inst, mem_ack, irq, ie_set,
    output mem_req, ir_ld, commit_e1, commit_e2, irq_save, irq_ack, bus_err, state
  );
endinterface

// File: rtl/puneh_seq_ctrl.sv
// PUNEH multi-cycle sequencer: req/ack memory handshake, 1/2-step execution, vectored IRQ, bus timeout trap.
// Optional single-step HOLD state is enabled by defining PUNEH_STEP_MODE_EN.
module puneh_seq_ctrl #(
  parameter int unsigned             IW            = 16,
  parameter int unsigned             OPW           = 4,
  parameter logic [(2**OPW)-1:0]     TWO_STEP_MASK = 16'h4434,
  parameter logic [(2**OPW)-1:0]     MEM1_MASK     = 16'h7EBE,
  parameter logic [(2**OPW)-1:0]     MEM2_MASK     = 16'h0434,
  parameter int unsigned             TIMEOUT       = 15
) (
  input logic            clk,
  input logic            rst,
  puneh_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC1 = 3'd1,
    EXEC2 = 3'd2,
    IRQ   = 3'd3,
    TRAP  = 3'd4
`ifdef PUNEH_STEP_MODE_EN
    , HOLD = 3'd5
`endif
  } state_t;

`ifdef PUNEH_STEP_MODE_EN
  localparam state_t REST = HOLD;
`else
  localparam state_t REST = FETCH;
`endif
  localparam logic [8:0] TMO = 9'(TIMEOUT);

  state_t         st;
  state_t         bnd;
  logic [OPW-1:0] op;
  logic           m1, m2, two;
  logic [7:0]     wcnt;
  logic [8:0]     wcnt_inc;
  logic           ie, berr;
  logic           req, done, ack, tmo;
  logic           unused_inst;

  assign op          = bus.inst[IW-1 -: OPW];
  assign unused_inst = ^bus.inst[IW-OPW-1:0];
  assign m1          = MEM1_MASK[op];
  assign m2          = MEM2_MASK[op];
  assign two         = TWO_STEP_MASK[op];

  // done: the current phase finishes this cycle (ack for memory phases, unconditional otherwise)
  always_comb begin
    req  = 1'b0;
    done = 1'b0;
    unique case (st)
      FETCH, IRQ: begin
        req  = 1'b1;
        done = bus.mem_ack;
      end
      EXEC1: begin
        req  = m1;
        done = m1 ? bus.mem_ack : 1'b1;
      end
      EXEC2: begin
        req  = m2;
        done = m2 ? bus.mem_ack : 1'b1;
      end
      default: ;
    endcase
  end

  assign ack      = req & bus.mem_ack;
  assign wcnt_inc = {1'b0, wcnt} + 9'd1;
  // trap when this unacknowledged cycle brings the wait count to TIMEOUT; a same-cycle ack wins
  assign tmo      = req & ~bus.mem_ack & (wcnt_inc == TMO);
  assign bnd      = (bus.irq & ie) ? IRQ : REST;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= FETCH;
      ie   <= 1'b0;
      wcnt <= '0;
      berr <= 1'b0;
    end else begin
      if (bus.ie_set)
        ie <= 1'b1;
      else if (st == IRQ && ack)
        ie <= 1'b0;

      wcnt <= (req && !bus.mem_ack && !tmo) ? wcnt_inc[7:0] : '0;

      if (tmo) begin
        st   <= TRAP;
        berr <= 1'b1;
      end else begin
        unique case (st)
          FETCH: if (done) st <= EXEC1;
          EXEC1: if (done) st <= two ? EXEC2 : bnd;
          EXEC2: if (done) st <= bnd;
          IRQ:   if (done) st <= REST;
          TRAP:  st <= TRAP;
`ifdef PUNEH_STEP_MODE_EN
          HOLD:  if (bus.step_go) st <= FETCH;
`endif
          default: st <= FETCH;
        endcase
      end
    end
  end

  // strobes are forced low while rst is held, even though st already reads FETCH
  assign bus.mem_req   = req & ~rst;
  assign bus.ir_ld     = (st == FETCH) & ack & ~rst;
  assign bus.commit_e1 = (st == EXEC1) & done & ~rst;
  assign bus.commit_e2 = (st == EXEC2) & done & ~rst;
  assign bus.irq_save  = (st == IRQ) & ~rst;
  assign bus.irq_ack   = (st == IRQ) & ack & ~rst;
  assign bus.bus_err   = berr;
  assign bus.state     = st;

endmodule

// File: tb/tb_puneh_seq_ctrl.sv
// Self-checking bench for puneh_seq_ctrl: directed scenarios plus randomized instruction streams
// against an instruction-level phase model. Honours PUNEH_STEP_MODE_EN when defined.
module tb_puneh_seq_ctrl;
  localparam int unsigned IW  = 16;
  localparam int unsigned TMO = 15;
  localparam logic [15:0] TWO_M = 16'h4434;
  localparam logic [15:0] M1_M  = 16'h7EBE;
  localparam logic [15:0] M2_M  = 16'h0434;
  localparam logic [2:0]  S_F = 3'd0, S_E1 = 3'd1, S_E2 = 3'd2, S_IRQ = 3'd3, S_TRAP = 3'd4;
  localparam logic [2:0]  S_HOLD = 3'd5;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   ie_m, go_irq, rnd_irq, irq_fix, ie_fix;
  int unsigned hold_len;

  puneh_seq_ctrl_if #(.IW(IW)) bus ();

  puneh_seq_ctrl #(
    .IW(IW), .OPW(4),
    .TWO_STEP_MASK(16'h4434), .MEM1_MASK(16'h7EBE), .MEM2_MASK(16'h0434),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {state, mem_req, ir_ld, commit_e1, commit_e2, irq_save, irq_ack, bus_err}
  function automatic logic [9:0] obs();
    return {bus.state, bus.mem_req, bus.ir_ld, bus.commit_e1, bus.commit_e2,
            bus.irq_save, bus.irq_ack, bus.bus_err};
  endfunction

  function automatic int unsigned rd();
    return ($urandom_range(7) == 0) ? TMO - 1 : $urandom_range(3);
  endfunction

  // One architectural phase: memory phases last dly wait cycles + 1 ack cycle, others 1 cycle.
  task automatic phase(input logic [2:0] code, input bit mem, input int unsigned dly,
                       input logic [IW-1:0] iv, output bit take);
    int unsigned n;
    bit last;
    logic [9:0] exp;
    take = 1'b0;
    n = mem ? dly + 1 : 1;
    for (int unsigned i = 0; i < n; i++) begin
      last = (i == n - 1);
      @(negedge clk);
`ifdef PUNEH_STEP_MODE_EN
      bus.step_go = 1'b0;
`endif
      bus.inst    = (code == S_F) ? IW'($urandom) : iv;
      bus.mem_ack = mem ? last : 1'($urandom);
      bus.irq     = rnd_irq ? 1'($urandom) : irq_fix;
      bus.ie_set  = rnd_irq ? ($urandom_range(7) == 0) : ie_fix;
      exp = {code, mem, (code == S_F) && last, (code == S_E1) && last, (code == S_E2) && last,
             code == S_IRQ, (code == S_IRQ) && last, 1'b0};
      #1 chk("phase", {22'd0, obs()}, {22'd0, exp});
      if (last) take = bus.irq & ie_m;
      if (code == S_IRQ && last) ie_m = bus.ie_set;
      else ie_m = ie_m | bus.ie_set;
    end
  endtask

  task automatic hold_phase();
`ifdef PUNEH_STEP_MODE_EN
    for (int unsigned i = 0; i <= hold_len; i++) begin
      @(negedge clk);
      bus.step_go = (i == hold_len);
      bus.mem_ack = 1'($urandom);
      bus.irq     = 1'($urandom);
      bus.ie_set  = 1'b0;
      #1 chk("hold", {22'd0, obs()}, {22'd0, S_HOLD, 7'd0});
    end
`endif
  endtask

  task automatic step(input logic [3:0] op, input int unsigned df, input int unsigned d1,
                      input int unsigned d2);
    bit ti;
    logic [IW-1:0] iv;
    iv = {op, 12'($urandom)};
    if (go_irq) begin
      phase(S_IRQ, 1'b1, df, iv, ti);
      go_irq = 1'b0;
      hold_phase();
    end else begin
      phase(S_F, 1'b1, df, iv, ti);
      phase(S_E1, M1_M[op], d1, iv, ti);
      if (TWO_M[op]) phase(S_E2, M2_M[op], d2, iv, ti);
      go_irq = ti;
      if (!ti) hold_phase();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ack = 1'b1;
    bus.irq     = 1'b1;
    bus.ie_set  = 1'b1;
    #1 chk("rst_async", {22'd0, obs()}, 32'd0);
    @(negedge clk);
    #1 chk("rst_hold", {22'd0, obs()}, 32'd0);
    @(posedge clk);
    #2;
    bus.mem_ack = 1'b0;
    bus.irq     = 1'b0;
    bus.ie_set  = 1'b0;
    rst    = 1'b0;
    ie_m   = 1'b0;
    go_irq = 1'b0;
  endtask

  task automatic trap_test();
    for (int unsigned i = 0; i < TMO; i++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      bus.irq     = 1'b0;
      bus.ie_set  = 1'b0;
      bus.inst    = IW'($urandom);
      #1 chk("trap_wait", {22'd0, obs()}, {22'd0, S_F, 1'b1, 6'd0});
    end
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_ack = 1'($urandom);
      bus.irq     = 1'b1;
      bus.ie_set  = 1'($urandom);
      #1 chk("trap_hold", {22'd0, obs()}, {22'd0, S_TRAP, 6'd0, 1'b1});
    end
    do_reset();
  endtask

  task automatic rst_mid();
    bit ti;
    logic [IW-1:0] iv;
    iv = {4'd2, 12'($urandom)};
    phase(S_F, 1'b1, 0, iv, ti);
    phase(S_E1, 1'b1, 0, iv, ti);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.inst    = iv;
      bus.mem_ack = 1'b0;
      bus.irq     = 1'b0;
      bus.ie_set  = 1'b0;
      #1 chk("e2_wait", {22'd0, obs()}, {22'd0, S_E2, 1'b1, 6'd0});
    end
    do_reset();
  endtask

  initial begin
    rst = 1'b1;
    bus.inst    = '0;
    bus.mem_ack = 1'b0;
    bus.irq     = 1'b0;
    bus.ie_set  = 1'b0;
`ifdef PUNEH_STEP_MODE_EN
    bus.step_go = 1'b0;
`endif
    ie_m = 1'b0; go_irq = 1'b0; rnd_irq = 1'b0; irq_fix = 1'b0; ie_fix = 1'b0;
    hold_len = 10;
    do_reset();

    repeat (4) step(4'd0, 0, 0, 0);
    hold_len = 2;
    step(4'd2, 0, 3, 0);
    step(4'd0, TMO - 1, 0, 0);
    step(4'd2, 0, TMO - 1, TMO - 1);
    step(4'd5, 1, 2, 0);

    ie_fix = 1'b1;
    step(4'd0, 0, 0, 0);
    ie_fix = 1'b0;
    irq_fix = 1'b1;
    step(4'd0, 0, 0, 0);
    step(4'd0, 1, 0, 0);
    step(4'd0, 0, 0, 0);
    step(4'd0, 0, 0, 0);
    irq_fix = 1'b0;
    for (int i = 0; i < 4 && go_irq; i++) step(4'd0, 0, 0, 0);

    trap_test();
    rst_mid();

    rnd_irq = 1'b1;
    repeat (300) begin
      hold_len = $urandom_range(3);
      step(4'($urandom), rd(), rd(), rd());
    end
    rnd_irq = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
endmodule
